led_count_sched: RTL and testbench
==================================

Name: led_count_sched

Overview:
- Controller that sequences the team's 8-bit LED up/down counter datapath.
- Generates the step enable from a speed-selectable prescaler.
- Applies the direction: manual, or automatic bounce between 0x00 and 0xFF.
- Handles run/pause from a push-button, and issues a one-cycle clear after reset.
- Sits between the board switches/button and the counter register, which keeps only the count state.

Parameters:
- TICK_BASE, 50000000, prescaler terminal count at slowest speed (sw=0); must be a multiple of 8; benches use 8.
- PRESC_W, 26, prescaler width; must hold TICK_BASE-1.
- DEB_CYCLES, 500000, button stable-time in cycles (used only with the optional feature); benches use 4.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous active-high reset.
- sw, input, 2, speed select; step period = TICK_BASE >> sw cycles.
- ud, input, 1, manual direction: 1=up, 0=down.
- bounce, input, 1, 1 = auto-bounce direction; 0 = manual direction from ud.
- run_btn, input, 1, asynchronous push-button; each press toggles RUN/PAUSE.
- count, input, 8, current counter value fed back from the datapath.
- cnt_en, output, 1, one-cycle step strobe to the counter.
- cnt_dir, output, 1, step direction, 1=up; valid whenever cnt_en=1.
- cnt_clr, output, 1, synchronous clear request to the counter.
- state, output, 2, FSM state for debug/LED: 00 CLEAR, 01 RUN, 10 PAUSE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: cnt_en=0, cnt_dir=1, cnt_clr=1, state=CLEAR, prescaler=0, dir_reg=1 (up), sync/edge regs=0.
- FSM:
  - CLEAR: cnt_clr=1 for exactly one cycle after reset deasserts, then RUN.
  - RUN <-> PAUSE: toggles on each detected button press.
  - A press detected while in CLEAR is ignored.
- Button path:
  - 2-FF synchronizer, then rising-edge detect.
  - Press at cycle N changes state at edge N+3.
- Prescaler (PAUSE/CLEAR):
  - Held at its current value in PAUSE; forced to 0 in CLEAR.
- Prescaler (RUN):
  - Counts 0..T-1 where T = TICK_BASE >> sw.
  - tick=1 when prescaler == T-1; prescaler then wraps to 0.
- Speed change:
  - sw is registered each cycle; a change resets the prescaler to 0 on the next cycle.
  - No tick is issued in that cycle; no partial-period glitch.
- Step strobe: cnt_en = tick registered (1-cycle latency after terminal count); 0 in PAUSE/CLEAR.
- Manual mode (bounce=0):
  - cnt_dir = ud sampled on the tick cycle.
  - Datapath wraps FF->00 and 00->FF; the scheduler does not block the wrap.
- Bounce mode (bounce=1), direction resolved on the tick cycle:
  - count==0xFF gives dir down.
  - count==0x00 gives dir up.
  - Otherwise dir = dir_reg.
  - dir_reg is updated to the resolved direction; wrap never occurs.
- Mode switch: bounce 0->1 loads dir_reg from ud on that cycle.
- Simultaneous press and tick: the tick cycle completes its step; the state change takes effect the next edge.
- Reset mid-operation: all outputs return to reset values immediately; CLEAR is re-entered on release.
- cnt_clr and cnt_en are never asserted in the same cycle.

Optional Feature:
- Macro: LED_COUNT_SCHED_DEBOUNCE_EN.
- Defined: the synchronized button must stay stable for DEB_CYCLES consecutive cycles before the debounced level updates. The edge detect acts on the debounced level, so press-to-state latency = DEB_CYCLES+3 cycles.
- Undefined: synchronizer plus edge detect only, latency 3 cycles; DEB_CYCLES is unused.

Decomposition:
- Package led_sched_pkg holds:
  - State encodings ST_CLEAR=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10.
  - CNT_MAX=8'hFF, CNT_MIN=8'h00, DIR_UP=1'b1, DIR_DN=1'b0.
- Sub-module led_tick_gen:
  - Contains the prescaler, sw register/change detect, hold input and tick output.
  - The FSM, button path and direction logic stay in the top.

Test Plan (TICK_BASE=8, DEB_CYCLES=4):
- Reset asserted 3 cycles then released -> cnt_clr=1 during reset plus one cycle after; state 00 then 01; cnt_dir=1.
- RUN, sw=0, ud=1, bounce=0 -> cnt_en pulses every 8 cycles, cnt_dir=1; sw=3 -> cnt_en every cycle, starting after the prescaler reset cycle.
- bounce=1, model counter at 0xFD going up -> directions up, up, down, down at counts FD, FE, FF, FE; count never wraps to 0x00.
- run_btn high 1 cycle in RUN -> state=10 at press+3; no cnt_en while paused. Second press -> state=01; prescaler resumes from its held value.
- Manual ud=0 at count 0x00 -> cnt_en with cnt_dir=0; model counter wraps to 0xFF.
- Reset asserted mid-RUN between ticks -> outputs at reset values asynchronously. With LED_COUNT_SCHED_DEBOUNCE_EN defined, a 2-cycle button glitch causes no state change.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared encodings for the LED counter scheduler: FSM states, count limits,
// step directions and the bounce-mode direction resolver.
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sched_state_e;

  localparam logic [7:0] CNT_MAX = 8'hFF;
  localparam logic [7:0] CNT_MIN = 8'h00;
  localparam logic       DIR_UP  = 1'b1;
  localparam logic       DIR_DN  = 1'b0;

  // Turn around at either end so the count bounces instead of wrapping.
  function automatic logic resolve_dir(input logic [7:0] value, input logic dir_prev);
    if (value == CNT_MAX) return DIR_DN;
    if (value == CNT_MIN) return DIR_UP;
    return dir_prev;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Speed-selectable prescaler: one tick every (TICK_BASE >> sw) cycles while run=1,
// held while run=0, zeroed by clear or by any change of sw.
module led_tick_gen #(
  parameter int unsigned TICK_BASE = 50000000,
  parameter int unsigned PRESC_W   = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       run,
  input  logic       clear,
  output logic       tick
);

  localparam logic [PRESC_W-1:0] BASE = PRESC_W'(TICK_BASE);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] term;
  logic [1:0]         sw_q;
  logic               sw_chg;

  assign term   = (BASE >> sw) - PRESC_W'(1);
  assign sw_chg = (sw != sw_q);
  // Suppressing the tick on a speed change avoids a short first period.
  assign tick   = run && !sw_chg && (presc == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      sw_q  <= 2'b00;
    end else begin
      sw_q <= sw;
      if (clear || sw_chg || tick) presc <= '0;
      else if (run)                presc <= presc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/led_count_sched.sv
// Scheduler for the 8-bit LED up/down counter: FSM, button path, direction.
// Optional button debounce enabled by defining LED_COUNT_SCHED_DEBOUNCE_EN.
module led_count_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned TICK_BASE  = 50000000,
  parameter int unsigned PRESC_W    = 26,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw,
  input  logic       ud,
  input  logic       bounce,
  input  logic       run_btn,
  input  logic [7:0] count,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic [1:0] state
);

  sched_state_e st;
  logic btn_s1, btn_s2, btn_lvl, btn_prev, press;
  logic tick, dir_reg, bounce_q, mode_entry, base_dir, step_dir;

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_s1   <= run_btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_lvl;
    end
  end

`ifdef LED_COUNT_SCHED_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_lvl;

  // The level only follows btn_s2 after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b0;
    end else if (btn_s2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      deb_lvl <= btn_s2;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign btn_lvl = deb_lvl;
`else
  assign btn_lvl = btn_s2;
`endif

  assign press = btn_lvl & ~btn_prev;

  led_tick_gen #(
    .TICK_BASE(TICK_BASE),
    .PRESC_W  (PRESC_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (reset),
    .sw   (sw),
    .run  (st == ST_RUN),
    .clear(st == ST_CLEAR),
    .tick (tick)
  );

  // Entering bounce mode seeds the remembered direction from the manual switch.
  assign mode_entry = bounce & ~bounce_q;
  assign base_dir   = mode_entry ? ud : dir_reg;
  assign step_dir   = bounce ? resolve_dir(count, base_dir) : ud;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= ST_CLEAR;
      cnt_clr  <= 1'b1;
      cnt_en   <= 1'b0;
      cnt_dir  <= DIR_UP;
      dir_reg  <= DIR_UP;
      bounce_q <= 1'b0;
    end else begin
      bounce_q <= bounce;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      if (mode_entry) dir_reg <= ud;
      case (st)
        ST_CLEAR: st <= ST_RUN;
        ST_RUN: begin
          if (tick) begin
            cnt_en  <= 1'b1;
            cnt_dir <= step_dir;
            if (bounce) dir_reg <= step_dir;
          end
          if (press) st <= ST_PAUSE;
        end
        ST_PAUSE: if (press) st <= ST_RUN;
        default: begin
          st      <= ST_CLEAR;
          cnt_clr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_count_sched.sv
// Self-checking bench for led_count_sched (TICK_BASE=8, DEB_CYCLES=4).
// Adapts press length/latency when LED_COUNT_SCHED_DEBOUNCE_EN is defined.
module tb_led_count_sched;

  localparam int TB_DEB = 4;
`ifdef LED_COUNT_SCHED_DEBOUNCE_EN
  localparam int PRESS_LEN = TB_DEB + 1;
  localparam int PRESS_LAT = TB_DEB + 3;
`else
  localparam int PRESS_LEN = 1;
  localparam int PRESS_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sw = 2'b00;
  logic       ud = 1'b1;
  logic       bounce = 1'b0;
  logic       run_btn = 1'b0;
  logic [7:0] count;
  logic       cnt_en, cnt_dir, cnt_clr;
  logic [1:0] state;

  logic [7:0] model_cnt = 8'h00;
  logic       load_req = 1'b0;
  logic [7:0] load_val = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_d;
  logic       sb_on = 1'b0;

  always #5 clk = ~clk;

  led_count_sched #(
    .TICK_BASE (8),
    .PRESC_W   (4),
    .DEB_CYCLES(TB_DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .ud     (ud),
    .bounce (bounce),
    .run_btn(run_btn),
    .count  (count),
    .cnt_en (cnt_en),
    .cnt_dir(cnt_dir),
    .cnt_clr(cnt_clr),
    .state  (state)
  );

  // Counter datapath model: clear, step with wrap, or bench preload.
  assign count = model_cnt;
  always @(posedge clk) begin
    if (load_req)     model_cnt <= load_val;
    else if (cnt_clr) model_cnt <= 8'h00;
    else if (cnt_en)  model_cnt <= cnt_dir ? model_cnt + 8'd1 : model_cnt - 8'd1;
  end

  // Scoreboard: every step while enabled must match the next expected direction.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (cnt_en === 1'b1 && cnt_clr === 1'b1) begin
        errors++;
        $display("FAIL en_clr_overlap: cnt_en=%b cnt_clr=%b required not both 1", cnt_en, cnt_clr);
      end
    end
    if (sb_on && cnt_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected: cnt_en=1 at %0t, no step expected", $time);
      end else begin
        exp_d = exp_q.pop_front();
        if (cnt_dir !== exp_d[0]) begin
          errors++;
          $display("FAIL step_dir: cnt_dir=%b required %b at %0t", cnt_dir, exp_d[0], $time);
        end
      end
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles until cnt_en is seen, or 0 if it never appears within max_cyc.
  task automatic wait_step(input int max_cyc, output int k);
    int n = 0;
    k = 0;
    while (k == 0 && n < max_cyc) begin
      tick_clk();
      n++;
      if (cnt_en === 1'b1) k = n;
    end
  endtask

  task automatic load_model(input logic [7:0] v);
    load_val = v;
    load_req = 1'b1;
    tick_clk();
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    reset = 1'b1;
    #1;
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL reset_clr: got %b want 1", cnt_clr); end
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", cnt_en); end
    checks++; if (cnt_dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b want 1", cnt_dir); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
    repeat (3) tick_clk();
    reset = 1'b0;
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clr_after_release: got %b want 1", cnt_clr); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL state_after_release: got %b want 00", state); end
    tick_clk();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL state_run: got %b want 01", state); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_one_cycle: got %b want 0", cnt_clr); end
    sb_on = 1'b1;
    exp_q.push_back(1'b1);
    wait_step(20, k);
    checks++; if (k != 8) begin errors++; $display("FAIL first_step_latency: got %0d want 8", k); end
  endtask

  task automatic test_speed();
    int k;
    repeat (2) begin
      exp_q.push_back(1'b1);
      wait_step(20, k);
      checks++; if (k != 8) begin errors++; $display("FAIL period_sw0: got %0d want 8", k); end
    end
    sw = 2'b11;
    repeat (5) exp_q.push_back(1'b1);
    wait_step(10, k);
    checks++; if (k != 2) begin errors++; $display("FAIL sw3_first: got %0d want 2", k); end
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL sw3_every_cycle: cycle %0d cnt_en=%b want 1", i, cnt_en); end
    end
    sw = 2'b00;
    exp_q.push_back(1'b1);
    wait_step(20, k);
    checks++; if (k != 9) begin errors++; $display("FAIL sw_back_to_0: got %0d want 9", k); end
  endtask

  task automatic test_pause();
    int k;
    logic saw_en;
    run_btn = 1'b1;
    for (int i = 1; i <= PRESS_LAT; i++) begin
      tick_clk();
      if (i == PRESS_LEN) run_btn = 1'b0;
      if (i == PRESS_LAT - 1) begin
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL pause_early: got %b want 01", state); end
      end
    end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state: got %b want 10", state); end
    saw_en = 1'b0;
    repeat (20) begin
      tick_clk();
      if (cnt_en !== 1'b0) saw_en = 1'b1;
    end
    checks++; if (saw_en !== 1'b0) begin errors++; $display("FAIL paused_step: saw cnt_en=1 want none"); end
    run_btn = 1'b1;
    for (int i = 1; i <= PRESS_LAT; i++) begin
      tick_clk();
      if (i == PRESS_LEN) run_btn = 1'b0;
      if (i == PRESS_LAT - 1) begin
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL resume_early: got %b want 10", state); end
      end
    end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL resume_state: got %b want 01", state); end
    exp_q.push_back(1'b1);
    wait_step(20, k);
    checks++; if (k != 8 - (PRESS_LAT % 8)) begin errors++; $display("FAIL resume_held_presc: got %0d want %0d", k, 8 - (PRESS_LAT % 8)); end
  endtask

  task automatic test_manual_wrap();
    int k;
    ud = 1'b0;
    load_model(8'h00);
    exp_q.push_back(1'b0);
    wait_step(20, k);
    checks++; if (k != 7) begin errors++; $display("FAIL wrap_step: got %0d want 7", k); end
    tick_clk();
    checks++; if (model_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_value: got %h want ff", model_cnt); end
  endtask

  task automatic test_bounce();
    int k;
    bounce = 1'b1;
    ud = 1'b1;
    load_model(8'hFD);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    wait_step(20, k);
    checks++; if (k != 6) begin errors++; $display("FAIL bounce_first: got %0d want 6", k); end
    ud = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_step(20, k);
      checks++; if (k != 8) begin errors++; $display("FAIL bounce_period: step %0d got %0d want 8", i, k); end
    end
    tick_clk();
    checks++; if (model_cnt !== 8'hFD) begin errors++; $display("FAIL bounce_value: got %h want fd", model_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    repeat (2) tick_clk();
    sb_on = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL mid_reset_clr: got %b want 1", cnt_clr); end
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL mid_reset_en: got %b want 0", cnt_en); end
    checks++; if (cnt_dir !== 1'b1) begin errors++; $display("FAIL mid_reset_dir: got %b want 1", cnt_dir); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mid_reset_state: got %b want 00", state); end
    repeat (2) tick_clk();
    reset = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mid_release_state: got %b want 00", state); end
    tick_clk();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL mid_rerun_state: got %b want 01", state); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL mid_rerun_clr: got %b want 0", cnt_clr); end
  endtask

`ifdef LED_COUNT_SCHED_DEBOUNCE_EN
  task automatic test_glitch();
    run_btn = 1'b1;
    repeat (2) tick_clk();
    run_btn = 1'b0;
    repeat (TB_DEB + 6) tick_clk();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL glitch_state: got %b want 01", state); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_speed();
    test_pause();
    test_manual_wrap();
    test_bounce();
    test_reset_mid();
`ifdef LED_COUNT_SCHED_DEBOUNCE_EN
    test_glitch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
